// File: rtl/uart_tx_arbiter.sv
// Four-way round-robin arbiter feeding one UART transmitter, with per-owner burst
// locking (forced release after MAX_BURST bytes) and a lock idle timeout.
//
// state  | meaning
// IDLE   | wait for UART idle and a candidate; a held lock keeps grant on the owner
// ACCEPT | one-cycle req_ready strobe to the owner; capture its byte if valid
// ISSUE  | hold uart_wr_en until the UART drops uart_tx_ready
// DRAIN  | wait for UART idle; then keep or release the lock
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = 16,
    parameter int LOCK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_last,
    output logic [3:0]  req_ready,
    output logic [7:0]  uart_data,
    output logic        uart_wr_en,
    input  logic        uart_tx_ready,
    output logic [3:0]  grant,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACCEPT, ISSUE, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [3:0]  grant_q, grant_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  ptr_q, ptr_d;
    logic        lock_q, lock_d;
    logic [4:0]  burst_q, burst_d;
    logic [7:0]  tmr_q, tmr_d;
    logic [7:0]  data_q, data_d;
    logic        last_q, last_d;

    logic        owner_valid;
    logic        timeout;
    logic        arb_locked;
    logic [1:0]  arb_ptr;
    logic [1:0]  idx;
    logic [1:0]  win;
    logic        found;

    assign owner_valid = req_valid[owner_q];
    // The lock timer is a down-counter; hitting zero on an idle owner releases the
    // lock and lets the other requesters arbitrate in that same cycle.
    assign timeout     = lock_q && !owner_valid && (tmr_q == 8'd0);
    assign arb_locked  = lock_q && !timeout;
    assign arb_ptr     = timeout ? owner_q + 2'd1 : ptr_q;

    always_comb begin
        found = 1'b0;
        win   = owner_q;
        idx   = arb_ptr;
        if (arb_locked) begin
            found = owner_valid;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                idx = arb_ptr + 2'(i);
                if (!found && req_valid[idx]) begin
                    found = 1'b1;
                    win   = idx;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        lock_d  = lock_q;
        burst_d = burst_q;
        tmr_d   = tmr_q;
        data_d  = data_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (lock_q && !owner_valid && (tmr_q != 8'd0)) begin
                    tmr_d = tmr_q - 8'd1;
                end
                if (timeout) begin
                    lock_d  = 1'b0;
                    burst_d = 5'd0;
                    ptr_d   = arb_ptr;
                    grant_d = 4'b0000;
                end
                if (uart_tx_ready && found) begin
                    grant_d = 4'b0001 << win;
                    owner_d = win;
                    state_d = ACCEPT;
                end
            end
            ACCEPT: begin
                if (owner_valid) begin
                    data_d  = req_data[{owner_q, 3'b000} +: 8];
                    last_d  = req_last[owner_q];
                    burst_d = burst_q + 5'd1;
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                    if (!lock_q) begin
                        grant_d = 4'b0000;
                    end
                end
            end
            ISSUE: begin
                if (!uart_tx_ready) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (uart_tx_ready) begin
                    state_d = IDLE;
                    // last and a full burst together still release only once
                    if (last_q || (burst_q == 5'(MAX_BURST))) begin
                        lock_d  = 1'b0;
                        burst_d = 5'd0;
                        ptr_d   = owner_q + 2'd1;
                        grant_d = 4'b0000;
                    end else begin
                        lock_d = 1'b1;
                        tmr_d  = 8'(LOCK_TIMEOUT - 1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= 4'b0000;
            owner_q <= 2'd0;
            ptr_q   <= 2'd0;
            lock_q  <= 1'b0;
            burst_q <= 5'd0;
            tmr_q   <= 8'd0;
            data_q  <= 8'h00;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            lock_q  <= lock_d;
            burst_q <= burst_d;
            tmr_q   <= tmr_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign req_ready  = (state_q == ACCEPT) ? grant_q : 4'b0000;
    assign uart_wr_en = (state_q == ISSUE);
    assign uart_data  = data_q;
    assign grant      = grant_q;
    assign busy       = (state_q != IDLE) || lock_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester byte queues, a UART model that logs
// writes, and a scoreboard of expected (requester, byte) pairs in arbitration order.
module tb_uart_tx_arbiter;

    localparam int LOCK_TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  uart_data;
    logic        uart_wr_en;
    logic        uart_tx_ready;
    logic [3:0]  grant;
    logic        busy;

    uart_tx_arbiter dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .uart_data(uart_data),
        .uart_wr_en(uart_wr_en), .uart_tx_ready(uart_tx_ready), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [7:0] data; logic last;} item_t;
    typedef struct packed {logic [1:0] req; logic [7:0] data;} exp_t;
    typedef struct packed {logic [3:0] grant; logic [7:0] data;} wr_t;

    item_t src_q[4][$];
    exp_t  sb[$];
    wr_t   wr_log[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int busy_cycles = 3;
    int accept_delay = 0;
    bit hold = 1'b0;
    int rise_cyc = 0;
    int viol = 0;
    int rr_cnt[4];

    always @(posedge clk) cyc <= cyc + 1;

    // requester sources: a byte leaves its queue the cycle after req_ready is seen
    logic [3:0] pop_pend = 4'b0000;
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!reset_n) pop_pend[i] = 1'b0;
            if (pop_pend[i]) begin
                if (src_q[i].size() > 0) void'(src_q[i].pop_front());
                pop_pend[i] = 1'b0;
            end
            if (req_ready[i]) pop_pend[i] = 1'b1;
            if (src_q[i].size() > 0) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = src_q[i][0].data;
                req_last[i]        = src_q[i][0].last;
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    end

    // UART model: accepts a write after accept_delay cycles of wr_en, then busy
    int busy_cnt = 0;
    int wr_seen = 0;
    initial uart_tx_ready = 1'b1;
    always @(negedge clk) begin
        if (!reset_n) begin
            busy_cnt = 0;
            wr_seen = 0;
            uart_tx_ready = !hold;
        end else if (hold) begin
            uart_tx_ready = 1'b0;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                uart_tx_ready = 1'b1;
                rise_cyc = cyc;
            end
        end else if (!uart_tx_ready) begin
            uart_tx_ready = 1'b1;
            rise_cyc = cyc;
        end else if (uart_wr_en) begin
            if (wr_seen < accept_delay) begin
                wr_seen++;
            end else begin
                wr_seen = 0;
                uart_tx_ready = 1'b0;
                busy_cnt = busy_cycles;
                wr_log.push_back('{grant: grant, data: uart_data});
            end
        end
    end

    // protocol monitor: req_ready one-hot within grant, uart_data stable between captures
    logic [7:0] prev_data = 8'h00;
    bit prev_rr = 1'b0;
    bit prev_rst = 1'b0;
    always @(negedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) rr_cnt[i] = 0;
        end else begin
            if (((req_ready & (req_ready - 4'd1)) != 4'd0) || ((req_ready & ~grant) != 4'd0)) viol++;
            if (prev_rst && !prev_rr && (uart_data != prev_data)) viol++;
            for (int i = 0; i < 4; i++) if (req_ready[i]) rr_cnt[i]++;
        end
        prev_data = uart_data;
        prev_rr = |req_ready;
        prev_rst = reset_n;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < 4; i++) src_q[i].delete();
        sb.delete();
        wr_log.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        clear_all();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic wait_writes(input string tag, input int n, input int budget);
        int k = 0;
        while (wr_log.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, wr_log.size() >= n, 1'b1);
    endtask

    task automatic wait_grant(input string tag, input logic [3:0] mask, input int budget);
        int k = 0;
        while (grant !== mask && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, grant, mask);
    endtask

    task automatic drain_check(input string tag);
        wr_t  w;
        exp_t e;
        check({tag, "_count"}, wr_log.size(), sb.size());
        while (wr_log.size() > 0 && sb.size() > 0) begin
            w = wr_log.pop_front();
            e = sb.pop_front();
            check({tag, "_data"}, w.data, e.data);
            check({tag, "_grant"}, w.grant, 4'b0001 << e.req);
        end
        wr_log.delete();
        sb.delete();
    endtask

    int got;

    initial begin
        // reset values
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 4'h0);
        check("rst_wr_en", uart_wr_en, 1'b0);
        check("rst_data", uart_data, 8'h00);
        check("rst_grant", grant, 4'h0);
        check("rst_busy", busy, 1'b0);
        @(posedge clk); #1 reset_n = 1'b1;

        // single byte from req1: latency, one ready pulse, wr_en held until UART busy
        accept_delay = 2;
        @(posedge clk); #1;
        src_q[1].push_back('{data: 8'h55, last: 1'b1});
        sb.push_back('{req: 2'd1, data: 8'h55});
        @(negedge clk);
        @(negedge clk);
        check("t1_grant", grant, 4'b0010);
        check("t1_ready", req_ready, 4'b0010);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t1_wr_en_held", uart_wr_en, 1'b1);
            check("t1_data", uart_data, 8'h55);
        end
        @(negedge clk);
        check("t1_wr_en_drop", uart_wr_en, 1'b0);
        wait_writes("t1_wait", 1, 50);
        drain_check("t1");
        check("t1_ready_pulses", rr_cnt[1], 1);
        accept_delay = 0;
        wait_grant("t1_release", 4'b0000, 50);
        // ptr now 2: req3 must beat req0
        @(posedge clk); #1;
        src_q[0].push_back('{data: 8'hA0, last: 1'b1});
        src_q[3].push_back('{data: 8'hD3, last: 1'b1});
        sb.push_back('{req: 2'd3, data: 8'hD3});
        sb.push_back('{req: 2'd0, data: 8'hA0});
        wait_writes("t1p_wait", 2, 100);
        drain_check("t1_ptr");

        // all four requesting, 10-cycle UART: order 0,1,2,3,0
        do_reset();
        busy_cycles = 10;
        @(posedge clk); #1;
        src_q[0].push_back('{data: 8'h01, last: 1'b1});
        src_q[0].push_back('{data: 8'h05, last: 1'b1});
        src_q[1].push_back('{data: 8'h02, last: 1'b1});
        src_q[2].push_back('{data: 8'h03, last: 1'b1});
        src_q[3].push_back('{data: 8'h04, last: 1'b1});
        sb.push_back('{req: 2'd0, data: 8'h01});
        sb.push_back('{req: 2'd1, data: 8'h02});
        sb.push_back('{req: 2'd2, data: 8'h03});
        sb.push_back('{req: 2'd3, data: 8'h04});
        sb.push_back('{req: 2'd0, data: 8'h05});
        wait_writes("t2_wait", 5, 400);
        repeat (40) @(negedge clk);
        drain_check("t2_rr");
        busy_cycles = 3;

        // req2 message of three bytes is not interrupted by req0
        do_reset();
        @(posedge clk); #1;
        src_q[2].push_back('{data: 8'hA1, last: 1'b0});
        src_q[2].push_back('{data: 8'hA2, last: 1'b0});
        src_q[2].push_back('{data: 8'hA3, last: 1'b1});
        sb.push_back('{req: 2'd2, data: 8'hA1});
        sb.push_back('{req: 2'd2, data: 8'hA2});
        sb.push_back('{req: 2'd2, data: 8'hA3});
        wait_grant("t3_grant", 4'b0100, 20);
        src_q[0].push_back('{data: 8'hB0, last: 1'b1});
        sb.push_back('{req: 2'd0, data: 8'hB0});
        wait_writes("t3_wait", 4, 200);
        repeat (10) @(negedge clk);
        drain_check("t3_lock");

        // req3 streams 20 bytes without last: forced release after 16, then req1
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            src_q[3].push_back('{data: 8'(8'h40 + i), last: 1'b0});
            if (i < 16) sb.push_back('{req: 2'd3, data: 8'(8'h40 + i)});
        end
        wait_grant("t4_grant", 4'b1000, 20);
        src_q[1].push_back('{data: 8'h11, last: 1'b1});
        sb.push_back('{req: 2'd1, data: 8'h11});
        wait_writes("t4_wait", 17, 600);
        drain_check("t4_burst");

        // lock timeout: req0 goes quiet after one byte, req2 waits out the timer
        do_reset();
        @(posedge clk); #1;
        src_q[0].push_back('{data: 8'hC0, last: 1'b0});
        sb.push_back('{req: 2'd0, data: 8'hC0});
        wait_writes("t5_wait1", 1, 50);
        src_q[2].push_back('{data: 8'hD2, last: 1'b1});
        sb.push_back('{req: 2'd2, data: 8'hD2});
        repeat (100) @(negedge clk);
        check("t5_grant_held", grant, 4'b0001);
        check("t5_busy_locked", busy, 1'b1);
        check("t5_no_ready2", rr_cnt[2], 0);
        wait_grant("t5_grant2", 4'b0100, 300);
        got = cyc;
        // tx_ready rises one cycle before the DUT samples it and enters IDLE
        check("t5_timeout_cycles", got - rise_cyc, LOCK_TIMEOUT + 1);
        wait_writes("t5_wait2", 2, 50);
        drain_check("t5");

        // reset during DRAIN with UART still busy
        do_reset();
        @(posedge clk); #1;
        src_q[1].push_back('{data: 8'h77, last: 1'b1});
        sb.push_back('{req: 2'd1, data: 8'h77});
        wait_writes("t6_wait1", 1, 50);
        hold = 1'b1;
        @(negedge clk);
        drain_check("t6_pre");
        #1 reset_n = 1'b0;
        clear_all();
        @(negedge clk);
        check("t6_rst_ready", req_ready, 4'h0);
        check("t6_rst_wr_en", uart_wr_en, 1'b0);
        check("t6_rst_data", uart_data, 8'h00);
        check("t6_rst_grant", grant, 4'h0);
        check("t6_rst_busy", busy, 1'b0);
        src_q[0].push_back('{data: 8'h99, last: 1'b1});
        sb.push_back('{req: 2'd0, data: 8'h99});
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (6) @(negedge clk);
        check("t6_no_grant", grant, 4'h0);
        check("t6_no_ready", rr_cnt[0], 0);
        check("t6_idle", busy, 1'b0);
        hold = 1'b0;
        wait_writes("t6_wait2", 1, 50);
        drain_check("t6_post");

        check("protocol_violations", viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
